// File: rtl/led_rotation_checker_if.sv
// led_rotation_checker_if: observed LED bus, controls and checker status outputs
interface led_rotation_checker_if #(
    parameter int ERR_CNT_W = 8
) ();
    logic [7:0]           pattern_in;
    logic                 enable;
    logic                 clear_errs;
    logic                 locked;
    logic                 step_pulse;
    logic                 err_pulse;
    logic [1:0]           err_code;
    logic [ERR_CNT_W-1:0] err_count;
    logic [15:0]          steps_seen;

    modport master (
        output pattern_in, enable, clear_errs,
        input  locked, step_pulse, err_pulse, err_code, err_count, steps_seen
    );

    modport slave (
        input  pattern_in, enable, clear_errs,
        output locked, step_pulse, err_pulse, err_code, err_count, steps_seen
    );
endinterface

// File: rtl/led_rotation_checker.sv
// led_rotation_checker: verifies a rotating LED bus steps left by one at a fixed interval
module led_rotation_checker #(
    parameter int CLK_FREQ    = 25_000_000,
    parameter int STEP_CYCLES = CLK_FREQ / 2,
    parameter int TOL_CYCLES  = 16,
    parameter int ERR_CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    led_rotation_checker_if.slave bus
);
    localparam int CW = $clog2(STEP_CYCLES + TOL_CYCLES + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CYCLES + TOL_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LO  = CW'(STEP_CYCLES - TOL_CYCLES);
    localparam logic [CW-1:0] CNT_HI  = CW'(STEP_CYCLES + TOL_CYCLES);

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

    state_t               state_q;
    logic [7:0]           prev_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 locked_q, step_pulse_q, err_pulse_q;
    logic [1:0]           err_code_q;
    logic [ERR_CNT_W-1:0] err_count_q;
    logic [15:0]          steps_q;
    logic                 change, rot_ok, time_ok, timeout;

    assign change  = bus.pattern_in != prev_q;
    assign rot_ok  = bus.pattern_in == {prev_q[6:0], prev_q[7]};
    assign time_ok = (cnt_q >= CNT_LO) && (cnt_q <= CNT_HI);
    assign timeout = cnt_q == CNT_MAX;

    // Interval counter: restarts at 1 on every change, otherwise counts up to the timeout value
    always_comb begin
        cnt_d = change ? CW'(1) : (timeout ? cnt_q : cnt_q + 1'b1);
    end

    // Checker FSM; prev follows the bus while idle so ACQUIRE captures a genuine edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            cnt_q        <= '0;
            locked_q     <= 1'b0;
            step_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= '0;
            err_count_q  <= '0;
            steps_q      <= '0;
        end else begin
            cnt_q        <= cnt_d;
            step_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            if (!bus.enable) begin
                state_q  <= IDLE;
                locked_q <= 1'b0;
                prev_q   <= bus.pattern_in;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= ACQUIRE;
                        prev_q  <= bus.pattern_in;
                    end
                    ACQUIRE: begin
                        if (change) begin
                            prev_q  <= bus.pattern_in;
                            state_q <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (change) begin
                            prev_q <= bus.pattern_in;
                            if (rot_ok && time_ok) begin
                                step_pulse_q <= 1'b1;
                                locked_q     <= 1'b1;
                                steps_q      <= (steps_q == 16'hFFFF) ? steps_q : steps_q + 1'b1;
                            end else begin
                                err_pulse_q <= 1'b1;
                                err_code_q  <= {~time_ok, ~rot_ok};
                                locked_q    <= 1'b0;
                                err_count_q <= (&err_count_q) ? err_count_q : err_count_q + 1'b1;
                            end
                        end else if (timeout) begin
                            err_pulse_q <= 1'b1;
                            err_code_q  <= 2'b10;
                            locked_q    <= 1'b0;
                            err_count_q <= (&err_count_q) ? err_count_q : err_count_q + 1'b1;
                            state_q     <= ACQUIRE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
            if (bus.clear_errs) err_count_q <= '0;
        end
    end

    assign bus.locked     = locked_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_code   = err_code_q;
    assign bus.err_count  = err_count_q;
    assign bus.steps_seen = steps_q;
endmodule

// File: tb/tb_led_rotation_checker.sv
// tb_led_rotation_checker: directed and randomized checks against a timestamp-based reference model
module tb_led_rotation_checker;
    localparam int STEP = 10;
    localparam int TOL  = 2;
    localparam int ECW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    led_rotation_checker_if #(.ERR_CNT_W(ECW)) bus ();

    led_rotation_checker #(
        .CLK_FREQ(20), .STEP_CYCLES(STEP), .TOL_CYCLES(TOL), .ERR_CNT_W(ECW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int           cyc = 0;
    int           m_last = 0;
    int           m_mode = 0;
    logic [7:0]   m_prev = '0;
    logic         m_locked = 0, m_step = 0, m_err = 0;
    logic [1:0]   m_code = '0;
    int           m_ecnt = 0;
    int           m_steps = 0;
    int           n_step_seen = 0, n_err_seen = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_prev = '0; m_locked = 0; m_step = 0; m_err = 0;
        m_code = '0; m_ecnt = 0; m_steps = 0; m_last = cyc;
    endtask

    task automatic model_error(input logic [1:0] code);
        m_err = 1; m_code = code; m_locked = 0;
        if (m_ecnt < (1 << ECW) - 1) m_ecnt++;
    endtask

    // mode: 0 idle, 1 acquiring, 2 tracking; gap is edges since the last observed change
    task automatic model_edge(input logic [7:0] p, input logic en, input logic clr);
        int gap;
        logic chg, timed;
        logic [7:0] rot;
        gap   = cyc - m_last;
        chg   = p != m_prev;
        timed = gap >= STEP - TOL && gap <= STEP + TOL;
        rot   = 8'(((m_prev << 1) | (m_prev >> 7)) & 8'hFF);
        m_step = 0; m_err = 0;
        if (!en) begin
            m_mode = 0; m_locked = 0; m_prev = p;
        end else if (m_mode == 0) begin
            m_mode = 1; m_prev = p;
        end else if (m_mode == 1) begin
            if (chg) begin m_prev = p; m_mode = 2; end
        end else if (chg) begin
            if (p == rot && timed) begin
                m_step = 1; m_locked = 1;
                if (m_steps < 16'hFFFF) m_steps++;
            end else model_error({!timed, p != rot});
            m_prev = p;
        end else if (gap == STEP + TOL + 1) begin
            model_error(2'b10);
            m_mode = 1;
        end
        if (chg) m_last = cyc;
        if (clr) m_ecnt = 0;
        cyc++;
    endtask

    task automatic compare_all();
        check("locked", int'(bus.locked), int'(m_locked));
        check("step_pulse", int'(bus.step_pulse), int'(m_step));
        check("err_pulse", int'(bus.err_pulse), int'(m_err));
        check("err_code", int'(bus.err_code), int'(m_code));
        check("err_count", int'(bus.err_count), m_ecnt);
        check("steps_seen", int'(bus.steps_seen), m_steps);
    endtask

    task automatic tick();
        logic [7:0] p;
        logic en, clr;
        p = bus.pattern_in; en = bus.enable; clr = bus.clear_errs;
        @(posedge clk);
        #1;
        model_edge(p, en, clr);
        n_step_seen += int'(bus.step_pulse);
        n_err_seen  += int'(bus.err_pulse);
        compare_all();
    endtask

    task automatic run(input logic [7:0] p, input int n);
        bus.pattern_in = p;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] p);
        return 8'(((p << 1) | (p >> 7)) & 8'hFF);
    endfunction

    initial begin
        logic [7:0] p;
        bus.pattern_in = '0; bus.enable = 0; bus.clear_errs = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        compare_all();

        // nominal rotation: 1F captured at 3E, good steps at 7C and F8
        run(8'h1F, 3);
        bus.enable = 1;
        run(8'h1F, 10);
        n_step_seen = 0;
        run(8'h3E, 10);
        check("no_pulse_at_capture", n_step_seen, 0);
        run(8'h7C, 10);
        run(8'hF8, 10);
        check("t1_steps", int'(bus.steps_seen), 2);
        check("t1_locked", int'(bus.locked), 1);
        check("t1_errs", int'(bus.err_count), 0);

        // late step (13 cycles) then a good one
        run(8'hF1, 13);
        run(8'hE3, 1);
        check("t2_err_pulse", int'(bus.err_pulse), 1);
        check("t2_code", int'(bus.err_code), 2);
        check("t2_locked", int'(bus.locked), 0);
        run(8'hE3, 9);
        run(8'hC7, 1);
        check("t2_relock", int'(bus.locked), 1);

        // bad rotation, then bad rotation and timing together
        run(8'hC7, 9);
        run(8'h8F, 10);
        run(8'h1F, 10);
        run(8'h8F, 1);
        check("t3_code_rot", int'(bus.err_code), 1);
        run(8'h8F, 4);
        run(8'h47, 1);
        check("t3_code_both", int'(bus.err_code), 3);

        // stall after a good step: exactly one timeout, then silent capture
        run(8'h47, 9);
        run(8'h8E, 1);
        n_err_seen = 0;
        run(8'h8E, 19);
        check("t4_one_timeout", n_err_seen, 1);
        check("t4_code", int'(bus.err_code), 2);
        check("t4_locked", int'(bus.locked), 0);
        n_step_seen = 0; n_err_seen = 0;
        run(8'h1D, 10);
        check("t4_capture_silent", n_step_seen + n_err_seen, 0);

        // saturation and clear-over-error priority
        bus.clear_errs = 1; tick(); bus.clear_errs = 0;
        check("t5_cleared", int'(bus.err_count), 0);
        run(8'h55, 10);
        run(8'h11, 10);
        run(8'h33, 10);
        run(8'h01, 10);
        check("t5_saturated", int'(bus.err_count), 3);
        bus.pattern_in = 8'h06; bus.clear_errs = 1; tick(); bus.clear_errs = 0;
        check("t5_clr_err_pulse", int'(bus.err_pulse), 1);
        check("t5_clr_count", int'(bus.err_count), 0);

        // randomized: mostly correct steps with jittered spacing, some corruption and gating
        p = 8'h06;
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            p = (r == 0) ? 8'($urandom) : rotl(p);
            bus.enable     = ($urandom_range(0, 19) != 0);
            bus.clear_errs = ($urandom_range(0, 14) == 0);
            bus.pattern_in = p;
            tick();
            bus.clear_errs = 0;
            bus.enable     = 1;
            run(p, int'($urandom_range(STEP - TOL - 2, STEP + TOL + 2)) - 1);
        end

        // async reset mid-interval, then disabled rotation stays silent
        run(8'h0F, 10);
        run(8'h1E, 10);
        run(8'h3C, 4);
        #2;
        rst = 1;
        #1;
        check("t6_locked", int'(bus.locked), 0);
        check("t6_steps", int'(bus.steps_seen), 0);
        check("t6_errs", int'(bus.err_count), 0);
        check("t6_code", int'(bus.err_code), 0);
        check("t6_pulses", int'(bus.step_pulse) + int'(bus.err_pulse), 0);
        bus.enable = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        n_step_seen = 0; n_err_seen = 0;
        p = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            p = rotl(p);
            run(p, 10);
        end
        check("t6_idle_silent", n_step_seen + n_err_seen, 0);
        check("t6_idle_unlocked", int'(bus.locked), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
